// File: rtl/mem_resp_pkg.sv
// Shared types for the multi-cycle data-memory responder.
// State encoding, word/lane widths and the latched request bundle.
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  function automatic logic addr_err(
    input logic [31:0] addr,
    input int unsigned depth
  );
    return {2'b00, addr[31:2]} >= depth;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, combinational read.
// Contents are intentionally not reset.
module dmem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data memory behind valid/ready request and response
// channels, with programmable wait states and range-error reporting.
module data_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  mem_req_t          r_req;
  mem_req_t          w_req_in;
  mem_req_t          w_src;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;
  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_mem_rdata;

  assign w_req_in = '{
    addr:  req_addr,
    we:    req_we,
    be:    req_be,
    wdata: req_wdata
  };

  assign req_ready  = (r_state == IDLE) && rst;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign w_accept   = req_valid && req_ready;

  // Zero-wait builds access straight from the live request on accept
  assign w_src    = (r_state == IDLE) ? w_req_in : r_req;
  assign w_err    = addr_err(w_src.addr, DEPTH);
  assign w_access = (r_state == IDLE)
                  ? (w_accept && (WC == 4'd0))
                  : ((r_state == WAIT) && (r_cnt == 4'd1));
  assign w_mem_we = w_access && w_src.we && !w_err;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (w_src.be),
    .i_idx   (w_src.addr[AW+1:2]),
    .i_wdata (w_src.wdata),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = WC;
          w_next    = (WC == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_req <= w_req_in;
      end
      if (w_access) begin
        r_rdata <= (!w_src.we && !w_err) ? w_mem_rdata : '0;
        r_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: directed loads/stores, errors,
// back-pressure, mid-transaction reset and a zero-wait instance.
module tb_data_mem_resp;

  localparam int W = 2;
  localparam int D = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        z_req_valid;
  logic        z_req_ready;
  logic [31:0] z_req_addr;
  logic        z_req_we;
  logic [3:0]  z_req_be;
  logic [31:0] z_req_wdata;
  logic        z_resp_valid;
  logic        z_resp_ready;
  logic [31:0] z_resp_rdata;
  logic        z_resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   nchecks = 0;
  int   nfail   = 0;
  int   cyc     = 0;
  bit   seen    = 0;

  data_mem_resp #(.DEPTH(D), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  data_mem_resp #(.DEPTH(D), .WAIT_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (z_req_valid),
    .req_ready  (z_req_ready),
    .req_addr   (z_req_addr),
    .req_we     (z_req_we),
    .req_be     (z_req_be),
    .req_wdata  (z_req_wdata),
    .resp_valid (z_resp_valid),
    .resp_ready (z_resp_ready),
    .resp_rdata (z_resp_rdata),
    .resp_err   (z_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid response cycle is compared to the queue head
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", cyc, q[0].due);
          seen = 1;
        end
        chk("resp_rdata", resp_rdata, q[0].rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (resp_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input bit expect_resp, output int acc);
    int n = 0;
    acc = -1;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_be    = be;
    req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("req_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (expect_resp) q.push_back('{rdata: er, err: ee, due: cyc + 1 + W});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_we    = 1'($urandom);
    req_be    = 4'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || !req_ready) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0 || !req_ready) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  int acc_a;
  int acc_b;
  int n;

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_we       = 1'b0;
    req_be       = '0;
    req_wdata    = '0;
    resp_ready   = 1'b1;
    z_req_valid  = 1'b0;
    z_req_addr   = '0;
    z_req_we     = 1'b0;
    z_req_be     = '0;
    z_req_wdata  = '0;
    z_resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    do_req(32'h10, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1, acc_a);
    do_req(32'h10, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1, acc_b);
    chk("throughput", acc_b - acc_a, W + 2);
    do_req(32'h10, 1, 4'b0010, 32'h0000AA00, 32'h0, 0, 1, acc_a);
    do_req(32'h10, 0, 4'h0, 32'h0, 32'hDEADAAEF, 0, 1, acc_a);
    do_req(32'h14, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 0, 1, acc_a);
    do_req(32'h14, 1, 4'b1001, 32'hA1B2C3D4, 32'h0, 0, 1, acc_a);
    do_req(32'h14, 0, 4'hF, 32'h0, 32'hA1FFFFD4, 0, 1, acc_a);
    do_req(32'h10, 1, 4'h0, 32'h55555555, 32'h0, 0, 1, acc_a);
    do_req(32'h13, 0, 4'h0, 32'h0, 32'hDEADAAEF, 0, 1, acc_a);
    do_req(32'h0, 1, 4'hF, 32'h12345678, 32'h0, 0, 1, acc_a);
    do_req(32'h1000, 0, 4'h0, 32'h0, 32'h0, 1, 1, acc_a);
    do_req(32'h1000, 1, 4'hF, 32'hBAD0BAD0, 32'h0, 1, 1, acc_a);
    do_req(32'h0, 0, 4'h0, 32'h0, 32'h12345678, 0, 1, acc_a);
    do_req(32'hFFFFFFFC, 0, 4'h0, 32'h0, 32'h0, 1, 1, acc_a);
    do_req(32'hFFC, 1, 4'hF, 32'h0BADCAFE, 32'h0, 0, 1, acc_a);
    do_req(32'hFFC, 0, 4'h0, 32'h0, 32'h0BADCAFE, 0, 1, acc_a);
    do_req(32'h20, 1, 4'hF, 32'h11111111, 32'h0, 0, 1, acc_a);
    wait_idle();

    // Reset lands while the store is still waiting
    do_req(32'h20, 1, 4'hF, 32'h22222222, 32'h0, 0, 0, acc_a);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_hold", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    do_req(32'h20, 0, 4'h0, 32'h0, 32'h11111111, 0, 1, acc_a);
    wait_idle();

    // Back-pressure with a competing request held during RESP
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    do_req(32'h10, 0, 4'h0, 32'h0, 32'hDEADAAEF, 0, 1, acc_a);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    repeat (5) @(negedge clk);
    chk("bp_still_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    do_req(32'h10, 0, 4'h0, 32'h0, 32'hDEADAAEF, 0, 1, acc_a);
    wait_idle();

    // Zero-wait instance: response right after the accept edge
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      #1;
      z_req_valid = 1'b1;
      z_req_addr  = 32'hC;
      z_req_we    = (t == 0);
      z_req_be    = 4'hF;
      z_req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("z_ready", {31'd0, z_req_ready}, 32'd1);
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      z_req_wdata = 32'h0;
      @(negedge clk);
      chk("z_valid", {31'd0, z_resp_valid}, 32'd1);
      chk("z_rdata", z_resp_rdata, (t == 0) ? 32'h0 : 32'hCAFEF00D);
      chk("z_err", {31'd0, z_resp_err}, 32'd0);
      @(negedge clk);
      chk("z_back_idle", {31'd0, z_resp_valid}, 32'd0);
    end

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
